// File: rtl/serial_sum_collector.sv
// ============================================================================
//  Module      : serial_sum_collector
//  Description : Reassembles an LSB-first serial sum stream plus the final
//                carry into a WIDTH+1-bit parallel result with valid/ready.
//                Optional self-check against latched operands is enabled by
//                defining SERIAL_SUM_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sum_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sum_bit,
    input  logic             bit_valid,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] check_a,
    input  logic [WIDTH-1:0] check_b,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             overrun,
    output logic             mismatch
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CARRY   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH:0]     r_result;
    logic               r_result_valid;
    logic               r_busy;
    logic               r_overrun;

    // HOLD only releases to a new start when the pending result is taken.
    logic w_start_accept;
    assign w_start_accept = start && ((r_state != ST_HOLD) || result_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_shreg        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (w_start_accept) begin
            r_state        <= ST_COLLECT;
            r_cnt          <= '0;
            r_shreg        <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
            r_overrun      <= 1'b0;
        end else begin
            if (bit_valid && (r_state != ST_COLLECT)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_COLLECT: begin
                    if (bit_valid) begin
                        r_shreg <= {sum_bit, r_shreg[WIDTH-1:1]};
                        r_cnt   <= r_cnt + c_cnt_one;
                        if (r_cnt == c_last_idx) begin
                            r_state <= ST_CARRY;
                        end
                    end
                end
                ST_CARRY: begin
                    r_result       <= {carry_in, r_shreg};
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

`ifdef SERIAL_SUM_CHECK_EN
    logic [WIDTH-1:0] r_check_a;
    logic [WIDTH-1:0] r_check_b;
    logic             r_mismatch;
    logic [WIDTH:0]   w_check_sum;
    logic             w_capture;

    assign w_check_sum = {1'b0, r_check_a} + {1'b0, r_check_b};
    assign w_capture   = (r_state == ST_CARRY) && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_check_a  <= '0;
            r_check_b  <= '0;
            r_mismatch <= 1'b0;
        end else if (w_start_accept) begin
            r_check_a  <= check_a;
            r_check_b  <= check_b;
            r_mismatch <= 1'b0;
        end else if (w_capture) begin
            r_mismatch <= ({carry_in, r_shreg} != w_check_sum);
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_check;
    assign w_unused_check = ^{check_a, check_b};
    assign mismatch       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_sum_collector.sv
// ============================================================================
//  Module      : tb_serial_sum_collector
//  Description : Directed self-checking bench for serial_sum_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sum_collector;

    localparam int WIDTH = 8;
`ifdef SERIAL_SUM_CHECK_EN
    localparam logic c_chk_en = 1'b1;
`else
    localparam logic c_chk_en = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sum_bit;
    logic             bit_valid;
    logic             carry_in;
    logic [WIDTH-1:0] check_a;
    logic [WIDTH-1:0] check_b;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;
    logic             overrun;
    logic             mismatch;

    int n_checks = 0;
    int n_pass   = 0;

    serial_sum_collector #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sum_bit      (sum_bit),
        .bit_valid    (bit_valid),
        .carry_in     (carry_in),
        .check_a      (check_a),
        .check_b      (check_b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .mismatch     (mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_bits(input logic [7:0] data, input int nbits, input bit gapped,
                             output bit busy_ok);
        busy_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            sum_bit   = data[i];
            bit_valid = 1'b1;
            cycle();
            bit_valid = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (gapped && (i != nbits - 1)) begin
                cycle();
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
    endtask

    bit ok;

    initial begin
        rst = 1'b1; start = 1'b0; sum_bit = 1'b0; bit_valid = 1'b0;
        carry_in = 1'b0; result_ready = 1'b0; check_a = '0; check_b = '0;
        cycle();
        cycle();
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", {28'h0, result_valid, busy, overrun, mismatch}, 32'h0);
        rst = 1'b0;
        cycle();

        // Basic sum 0x96, carry 0
        check_a = 8'h50; check_b = 8'h46; carry_in = 1'b0;
        pulse_start();
        check("basic_busy_after_start", 32'(busy), 32'h1);
        send_bits(8'h96, WIDTH, 1'b0, ok);
        check("basic_busy_during", 32'(ok), 32'h1);
        check("basic_valid_in_carry", 32'(result_valid), 32'h0);
        cycle();
        check("basic_valid_rise", 32'(result_valid), 32'h1);
        check("basic_result", 32'(result), 32'h096);
        check("basic_busy_hold", 32'(busy), 32'h0);
        check("basic_mismatch", 32'(mismatch), 32'h0);
        cycle();
        check("basic_valid_held", 32'(result_valid), 32'h1);
        release_result();
        check("basic_valid_drop", 32'(result_valid), 32'h0);
        check("basic_result_kept", 32'(result), 32'h096);

        // Carry out: 0xFF + 0x01
        check_a = 8'hFF; check_b = 8'h01; carry_in = 1'b1;
        pulse_start();
        send_bits(8'h00, WIDTH, 1'b0, ok);
        cycle();
        check("carry_result", 32'(result), 32'h100);
        check("carry_valid", 32'(result_valid), 32'h1);
        check("carry_mismatch", 32'(mismatch), 32'h0);

        // start in HOLD without ready is ignored; with ready goes straight to COLLECT
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("hold_start_ignored_valid", 32'(result_valid), 32'h1);
        check("hold_start_ignored_busy", 32'(busy), 32'h0);
        check_a = 8'h90; check_b = 8'h06; carry_in = 1'b0;
        start = 1'b1; result_ready = 1'b1;
        cycle();
        start = 1'b0; result_ready = 1'b0;
        check("hold_start_ready_valid", 32'(result_valid), 32'h0);
        check("hold_start_ready_busy", 32'(busy), 32'h1);

        // Gapped stream of 0x96
        send_bits(8'h96, WIDTH, 1'b1, ok);
        check("gap_busy_during", 32'(ok), 32'h1);
        check("gap_valid_in_carry", 32'(result_valid), 32'h0);
        cycle();
        check("gap_result", 32'(result), 32'h096);
        check("gap_valid", 32'(result_valid), 32'h1);
        release_result();

        // Restart after 3 bits, then 0xA5
        check_a = 8'hA0; check_b = 8'h05; carry_in = 1'b0;
        pulse_start();
        send_bits(8'hFF, 3, 1'b0, ok);
        pulse_start();
        send_bits(8'hA5, WIDTH, 1'b0, ok);
        cycle();
        check("restart_result", 32'(result), 32'h0A5);
        check("restart_overrun_clear", 32'(overrun), 32'h0);
        sum_bit = 1'b1; bit_valid = 1'b1;
        cycle();
        bit_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        check("overrun_result_kept", 32'(result), 32'h0A5);
        check("overrun_valid_kept", 32'(result_valid), 32'h1);
        release_result();
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Check failure: 0x5A + 0x3C = 0x96, stream 0x97
        check_a = 8'h5A; check_b = 8'h3C; carry_in = 1'b0;
        pulse_start();
        check("start_clears_overrun", 32'(overrun), 32'h0);
        send_bits(8'h97, WIDTH, 1'b0, ok);
        cycle();
        check("chk_result", 32'(result), 32'h097);
        check("chk_mismatch", 32'(mismatch), 32'(c_chk_en));
        release_result();

        // Reset mid-collect
        check_a = 8'h90; check_b = 8'h06;
        pulse_start();
        send_bits(8'h0F, 4, 1'b0, ok);
        rst = 1'b1;
        #1;
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_flags", {28'h0, result_valid, busy, overrun, mismatch}, 32'h0);
        cycle();
        rst = 1'b0;
        cycle();
        pulse_start();
        send_bits(8'h96, WIDTH, 1'b0, ok);
        cycle();
        check("postrst_result", 32'(result), 32'h096);
        check("postrst_valid", 32'(result_valid), 32'h1);
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
